// File: rtl/hacd_zchunk_decompressor.sv
`default_nettype none
// ============================================================================
// hacd_zchunk_decompressor : zero-chunk page expander (optional size check
// enabled by macro HACD_DECOMP_SIZE_CHECK_EN)
// Revision: 1.0
// ============================================================================
module hacd_zchunk_decompressor #(
    parameter int DATA_WIDTH      = 512,
    parameter int NUM_CHUNKS      = 4,
    parameter int LINES_PER_CHUNK = 16,
    parameter int SIZE_WIDTH      = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  decomp_start,
    input  logic [SIZE_WIDTH-1:0] comp_size,
    input  logic                  rdfifo_empty,
    output logic                  rd_req,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic [1:0]            rd_rresp,
    input  logic                  rd_valid,
    input  logic                  wrfifo_full,
    output logic                  wr_req,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  decomp_done,
    output logic                  decomp_err,
    output logic [1:0]            err_code,
    output logic                  busy
);

    localparam int C_LCNT_W = $clog2(LINES_PER_CHUNK);
    localparam int C_CIDX_W = $clog2(NUM_CHUNKS + 1);
    localparam logic [C_LCNT_W-1:0] C_LAST_LINE = C_LCNT_W'(LINES_PER_CHUNK - 1);
    localparam logic [C_CIDX_W-1:0] C_END_CHUNK = C_CIDX_W'(NUM_CHUNKS);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_META  = 4'd1,
        ST_CHECK = 4'd2,
        ST_SEL   = 4'd3,
        ST_ZERO  = 4'd4,
        ST_COPY  = 4'd5,
        ST_DONE  = 4'd6,
        ST_ERROR = 4'd7,
        ST_DRAIN = 4'd8
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_CHUNKS-1:0] bitmap_q, bitmap_d;
    logic [C_CIDX_W-1:0]   chunk_idx_q, chunk_idx_d;
    logic [C_LCNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic                  outst_q, outst_d;
    logic                  pend_q, pend_d;
    logic                  rd_req_q, rd_req_d;
    logic                  wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  busy_q, busy_d;

    logic cur_zero;
    logic line_adv;
    logic abort;
    logic size_ok;

`ifdef HACD_DECOMP_SIZE_CHECK_EN
    localparam int C_EXP_W = SIZE_WIDTH + 1;
    logic [C_EXP_W-1:0] zero_cnt;
    logic [C_EXP_W-1:0] exp_size;

    always_comb begin
        zero_cnt = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            zero_cnt = zero_cnt + C_EXP_W'(bitmap_q[i]);
        end
        exp_size = C_EXP_W'(1) + C_EXP_W'(LINES_PER_CHUNK) * (C_EXP_W'(NUM_CHUNKS) - zero_cnt);
        size_ok  = (exp_size == {1'b0, comp_size});
    end
`else
    logic unused_comp_size;
    assign unused_comp_size = ^comp_size;
    assign size_ok          = 1'b1;
`endif

    always_comb begin
        cur_zero = 1'b0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (chunk_idx_q == C_CIDX_W'(i)) begin
                cur_zero = bitmap_q[i];
            end
        end
    end

    assign abort = !decomp_start &&
                   (state_q inside {ST_META, ST_CHECK, ST_SEL, ST_ZERO, ST_COPY});

    always_comb begin
        state_d     = state_q;
        bitmap_d    = bitmap_q;
        chunk_idx_d = chunk_idx_q;
        line_cnt_d  = line_cnt_q;
        outst_d     = outst_q & ~rd_valid;
        pend_d      = pend_q;
        rd_req_d    = 1'b0;
        wr_req_d    = 1'b0;
        wr_data_d   = wr_data_q;
        err_code_d  = err_code_q;
        line_adv    = 1'b0;

        if (abort) begin
            // An outstanding read must still be absorbed before going idle.
            pend_d  = 1'b0;
            state_d = (outst_q && !rd_valid) ? ST_DRAIN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    chunk_idx_d = '0;
                    line_cnt_d  = '0;
                    pend_d      = 1'b0;
                    err_code_d  = 2'd0;
                    if (decomp_start && !rdfifo_empty) begin
                        state_d = ST_META;
                    end
                end
                ST_META: begin
                    if (outst_q) begin
                        if (rd_valid) begin
                            if (rd_rresp != 2'd0) begin
                                state_d    = ST_ERROR;
                                err_code_d = 2'd1;
                            end else begin
                                bitmap_d = rd_data[NUM_CHUNKS-1:0];
                                state_d  = ST_CHECK;
                            end
                        end
                    end else if (!rdfifo_empty) begin
                        rd_req_d = 1'b1;
                        outst_d  = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (!size_ok) begin
                        state_d    = ST_ERROR;
                        err_code_d = 2'd2;
                    end else begin
                        chunk_idx_d = '0;
                        state_d     = ST_SEL;
                    end
                end
                ST_SEL: begin
                    line_cnt_d = '0;
                    if (chunk_idx_q == C_END_CHUNK) begin
                        state_d = ST_DONE;
                    end else if (cur_zero) begin
                        state_d = ST_ZERO;
                    end else begin
                        state_d = ST_COPY;
                    end
                end
                ST_ZERO: begin
                    if (!wrfifo_full) begin
                        wr_req_d  = 1'b1;
                        wr_data_d = '0;
                        line_adv  = 1'b1;
                    end
                end
                ST_COPY: begin
                    // A line that lands while the write FIFO is almost full is
                    // parked in wr_data_q until a slot can be claimed.
                    if (pend_q) begin
                        if (!wrfifo_full) begin
                            wr_req_d = 1'b1;
                            pend_d   = 1'b0;
                            line_adv = 1'b1;
                        end
                    end else if (outst_q) begin
                        if (rd_valid) begin
                            if (rd_rresp != 2'd0) begin
                                state_d    = ST_ERROR;
                                err_code_d = 2'd1;
                            end else begin
                                wr_data_d = rd_data;
                                if (!wrfifo_full) begin
                                    wr_req_d = 1'b1;
                                    line_adv = 1'b1;
                                end else begin
                                    pend_d = 1'b1;
                                end
                            end
                        end
                    end else if (!rdfifo_empty && !wrfifo_full) begin
                        rd_req_d = 1'b1;
                        outst_d  = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!decomp_start) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    if (!decomp_start) begin
                        state_d    = ST_IDLE;
                        err_code_d = 2'd0;
                    end
                end
                ST_DRAIN: begin
                    if (rd_valid || !outst_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (line_adv) begin
            line_cnt_d = line_cnt_q + 1'b1;
            if (line_cnt_q == C_LAST_LINE) begin
                chunk_idx_d = chunk_idx_q + 1'b1;
                state_d     = ST_SEL;
            end
        end

        done_d = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERROR);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            bitmap_q    <= '0;
            chunk_idx_q <= '0;
            line_cnt_q  <= '0;
            outst_q     <= 1'b0;
            pend_q      <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitmap_q    <= bitmap_d;
            chunk_idx_q <= chunk_idx_d;
            line_cnt_q  <= line_cnt_d;
            outst_q     <= outst_d;
            pend_q      <= pend_d;
            rd_req_q    <= rd_req_d;
            wr_req_q    <= wr_req_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_req      = rd_req_q;
    assign wr_req      = wr_req_q;
    assign wr_data     = wr_data_q;
    assign decomp_done = done_q;
    assign decomp_err  = err_q;
    assign err_code    = err_code_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hacd_zchunk_decompressor.sv
`default_nettype none
// ============================================================================
// tb_hacd_zchunk_decompressor : scoreboard bench with FIFO models and page model
// Revision: 1.0
// ============================================================================
module tb_hacd_zchunk_decompressor;

    localparam int DW  = 512;
    localparam int NC  = 4;
    localparam int LPC = 16;
    localparam int SW  = 14;
`ifdef HACD_DECOMP_SIZE_CHECK_EN
    localparam bit SIZE_CHK = 1'b1;
`else
    localparam bit SIZE_CHK = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          decomp_start;
    logic [SW-1:0] comp_size;
    logic          rdfifo_empty;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_rresp;
    logic          rd_valid;
    logic          wrfifo_full;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          decomp_done;
    logic          decomp_err;
    logic [1:0]    err_code;
    logic          busy;

    hacd_zchunk_decompressor #(
        .DATA_WIDTH      (DW),
        .NUM_CHUNKS      (NC),
        .LINES_PER_CHUNK (LPC),
        .SIZE_WIDTH      (SW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .decomp_start (decomp_start),
        .comp_size    (comp_size),
        .rdfifo_empty (rdfifo_empty),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_rresp     (rd_rresp),
        .rd_valid     (rd_valid),
        .wrfifo_full  (wrfifo_full),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .decomp_done  (decomp_done),
        .decomp_err   (decomp_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 clk_i = ~clk_i;

    logic [DW+1:0] rq[$];      // read FIFO contents: {rresp, line}
    logic [DW-1:0] exp_q[$];   // expected write stream
    logic [DW-1:0] exp_line;
    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int full_mode = 0;
    int rd_lat_max = 2;
    int exp_rd;
    int exp_left;
    int exp_outcome;           // 0 done, 1 bus error, 2 size mismatch
    logic full_seen = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Write FIFO: almost-full pattern selected by full_mode.
    initial begin : wr_fifo_model
        int cyc;
        cyc = 0;
        wrfifo_full = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            case (full_mode)
                1:       wrfifo_full = ((cyc / 3) % 2) == 1;
                2:       wrfifo_full = ($urandom_range(3, 0) == 0);
                default: wrfifo_full = 1'b0;
            endcase
        end
    end

    always @(posedge clk_i) full_seen <= wrfifo_full;

    // Read FIFO: pops on rd_req and returns the line after a random latency.
    initial begin : rd_fifo_model
        logic [DW+1:0] it;
        int lat;
        rd_valid     = 1'b0;
        rd_data      = '0;
        rd_rresp     = 2'd0;
        rdfifo_empty = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_ni && rd_req) begin
                if (rq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_on_empty actual=1 required=0");
                end else begin
                    it = rq.pop_front();
                    rdfifo_empty = (rq.size() == 0);
                    lat = $urandom_range(rd_lat_max, 1);
                    repeat (lat) begin
                        @(posedge clk_i);
                        #1;
                    end
                    rd_data  = it[DW-1:0];
                    rd_rresp = it[DW+1:DW];
                    rd_valid = 1'b1;
                    @(posedge clk_i);
                    #1;
                    rd_valid = 1'b0;
                end
            end
            rdfifo_empty = (rq.size() == 0);
        end
    end

    // Monitor: every write is popped from the scoreboard and compared.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (rd_req) rd_cnt++;
            if (wr_req) begin
                wr_cnt++;
                checks++;
                if (full_seen) begin
                    failures++;
                    $display("FAIL wr_while_full actual=1 required=0");
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected actual=%h required=none", wr_data);
                end else begin
                    exp_line = exp_q.pop_front();
                    if (wr_data !== exp_line) begin
                        failures++;
                        $display("FAIL wr_data actual=%h required=%h", wr_data, exp_line);
                    end
                end
            end
        end
    end

    // Loads the read FIFO for one page and derives the expected outcome.
    task automatic prepare(input logic [3:0] bm, input int size, input int bad,
                           input bit meta_bad, input int extra);
        logic [DW-1:0] dl[$];
        logic [DW-1:0] meta;
        int ndata;
        int k;
        bit stop;
        exp_q.delete();
        rq.delete();
        wr_cnt    = 0;
        rd_cnt    = 0;
        comp_size = SW'(size);
        ndata     = LPC * (NC - $countones(bm));
        meta      = rand_line();
        meta[NC-1:0] = bm;
        rq.push_back({meta_bad ? 2'd2 : 2'd0, meta});
        for (int j = 0; j < ndata + extra; j++) begin
            dl.push_back(rand_line());
            rq.push_back({(j == bad) ? 2'd2 : 2'd0, dl[j]});
        end
        exp_rd      = 1;
        exp_outcome = 0;
        k           = 0;
        stop        = 1'b0;
        if (meta_bad) begin
            exp_outcome = 1;
        end else if (SIZE_CHK && size != 1 + LPC * (NC - $countones(bm))) begin
            exp_outcome = 2;
        end else begin
            for (int c = 0; c < NC && !stop; c++) begin
                for (int l = 0; l < LPC && !stop; l++) begin
                    if (bm[c]) begin
                        exp_q.push_back('0);
                    end else begin
                        exp_rd++;
                        if (k == bad) begin
                            exp_outcome = 1;
                            stop = 1'b1;
                        end else begin
                            exp_q.push_back(dl[k]);
                            k++;
                        end
                    end
                end
            end
        end
        exp_left = 1 + ndata + extra - exp_rd;
    endtask

    task automatic run_page(input string name);
        int t;
        decomp_start = 1'b1;
        t = 0;
        while (!(decomp_done || decomp_err) && t < 4000) begin
            @(negedge clk_i);
            t++;
        end
        check({name, "_finish_in_time"}, t < 4000, 1);
        repeat (6) @(negedge clk_i);
        check({name, "_done"}, decomp_done, exp_outcome == 0);
        check({name, "_err"}, decomp_err, exp_outcome != 0);
        check({name, "_err_code"}, err_code, exp_outcome);
        check({name, "_rd_count"}, rd_cnt, exp_rd);
        check({name, "_fifo_left"}, rq.size(), exp_left);
        check({name, "_writes_missing"}, exp_q.size(), 0);
        check({name, "_busy"}, busy, 1);
        decomp_start = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_done"}, decomp_done, 0);
        check({name, "_idle_err"}, {decomp_err, err_code}, 0);
        repeat (2) @(negedge clk_i);
    endtask

    task automatic abort_test();
        int t;
        full_mode  = 0;
        rd_lat_max = 3;
        prepare(4'b0000, 1 + NC * LPC, -1, 1'b0, 0);
        decomp_start = 1'b1;
        t = 0;
        while (!(rd_req && wr_cnt >= 5) && t < 2000) begin
            @(posedge clk_i);
            #1;
            t++;
        end
        check("abort_reach_copy", t < 2000, 1);
        decomp_start = 1'b0;
        exp_q.delete();
        t = 0;
        while (!rd_valid && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        check("abort_rd_valid_seen", rd_valid, 1);
        @(negedge clk_i);
        check("abort_idle_busy", busy, 0);
        check("abort_done", decomp_done, 0);
        check("abort_err", decomp_err, 0);
        repeat (5) @(negedge clk_i);
        check("abort_rd_count", rd_cnt, wr_cnt + 2);
        check("abort_stays_idle", busy, 0);
    endtask

    initial begin : main
        logic [3:0] bm;
        rst_ni       = 1'b0;
        decomp_start = 1'b0;
        comp_size    = '0;
        repeat (3) @(negedge clk_i);
        check("rst_rd_req", rd_req, 0);
        check("rst_wr_req", wr_req, 0);
        check("rst_wr_data", |wr_data, 0);
        check("rst_done", decomp_done, 0);
        check("rst_err", decomp_err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_busy", busy, 0);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        prepare(4'b0101, 33, -1, 1'b0, 0);
        run_page("mixed");
        prepare(4'b1111, 1, -1, 1'b0, 5);
        run_page("all_zero");
        prepare(4'b0000, 33, -1, 1'b0, 0);
        run_page("size_mismatch");
        prepare(4'b1000, 49, LPC + 4, 1'b0, 0);
        run_page("bus_err");
        prepare(4'b0110, 33, -1, 1'b1, 0);
        run_page("meta_err");

        full_mode = 1;
        prepare(4'b0101, 33, -1, 1'b0, 0);
        run_page("full_toggle_mixed");
        prepare(4'b0000, 65, -1, 1'b0, 0);
        run_page("full_toggle_copy");

        for (int n = 0; n < 6; n++) begin
            bm         = 4'($urandom);
            full_mode  = $urandom_range(2, 0);
            rd_lat_max = $urandom_range(3, 1);
            prepare(bm, 1 + LPC * (NC - $countones(bm)), -1, 1'b0, $urandom_range(2, 0));
            run_page("random");
        end

        abort_test();
        full_mode  = 2;
        rd_lat_max = 2;
        prepare(4'b0010, 49, -1, 1'b0, 0);
        run_page("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
